alu_core: RTL and testbench

//  WIDTH-bit integer ALU for the vector-CPU execute stage (one instance per lane).

---
 rtl/alu_core.sv | 114 +++++++++++
 tb/tb_alu_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: WIDTH-bit integer ALU with combinational NZVC flags and a registered status copy
// Optional feature macro: ALU_DIV_EN (defined -> DIV/MOD implemented; undefined -> no divider, DIV/MOD give Out=0, V=1)
// Ports:
//   clk      clock for the status register
//   rst      asynchronous active-high reset of flags_q
//   flag_we  capture {N,Z,V,C} into flags_q on the next rising clk
//   A, B     operands
//   sel      operation select
//   Out      combinational result
//   N Z V C  combinational flags
//   flags_q  registered {N,Z,V,C}
module alu_core #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_we,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] Out,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic [3:0]       flags_q
);
    localparam int M = WIDTH - 1;

    logic [WIDTH:0]       sum, diff, sll_w, srl_w, sra_w;
    logic [2*WIDTH-1:0]   prod;
    logic [4:0]           sh;
    logic                 add_v, sub_v, mul_hi;

    assign sh     = B[4:0];
    assign sum    = {1'b0, A} + {1'b0, B};
    assign diff   = {1'b0, A} - {1'b0, B};
    assign prod   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign mul_hi = |prod[2*WIDTH-1:WIDTH];
    assign add_v  = ~(A[M] ^ B[M]) & (sum[M] ^ A[M]);
    assign sub_v  = (A[M] ^ B[M]) & (diff[M] ^ A[M]);
    // One extra bit beside the operand catches the last bit shifted out;
    // amounts beyond WIDTH naturally leave zeros (or sign bits for SRA) there.
    assign sll_w  = {1'b0, A} << sh;
    assign srl_w  = {A, 1'b0} >> sh;
    assign sra_w  = $signed({A, 1'b0}) >>> sh;

`ifdef ALU_DIV_EN
    logic             bz;
    logic [WIDTH-1:0] quo, rem;
    assign bz  = (B == '0);
    assign quo = bz ? '1 : A / B;
    assign rem = bz ? '1 : A % B;
`endif

    always_comb begin
        Out = '0;
        V   = 1'b0;
        C   = 1'b0;
        case (sel)
            4'h0: Out = A & B;
            4'h1: Out = A | B;
            4'h2: Out = A ^ B;
            4'h3: Out = ~A;
            4'h4: begin
                Out = sum[M:0];
                C   = sum[WIDTH];
                V   = add_v;
            end
            4'h5, 4'hD: begin
                Out = diff[M:0];
                C   = ~diff[WIDTH];
                V   = sub_v;
            end
            4'h6: begin
`ifdef ALU_DIV_EN
                Out = quo;
                V   = bz;
`else
                V   = 1'b1;
`endif
            end
            4'h7: begin
                Out = prod[M:0];
                C   = mul_hi;
                V   = mul_hi;
            end
            4'h8: {C, Out} = sll_w;
            4'h9: {Out, C} = srl_w;
            4'hA: {Out, C} = sra_w;
            4'hB: Out = B;
            4'hC: begin
`ifdef ALU_DIV_EN
                Out = rem;
                V   = bz;
`else
                V   = 1'b1;
`endif
            end
            4'hE: Out = (A < B) ? A : B;
            4'hF: Out = (A > B) ? A : B;
            default: Out = '0;
        endcase
        N = Out[M];
        Z = ~|Out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= 4'b0;
        else if (flag_we)
            flags_q <= {N, Z, V, C};
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: self-checking bench for alu_core using an expected-value queue
module tb_alu_core;
    localparam int W = 19;
    localparam longint MK = (longint'(1) << W) - 1;
    localparam longint HALF = longint'(1) << (W - 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flag_we = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [3:0]   sel = '0;
    logic [W-1:0] out;
    logic         n, z, v, c;
    logic [3:0]   flags_q;

    logic [W+3:0] sb[$];
    logic [W+3:0] e;
    int checks = 0;
    int errors = 0;

    alu_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .A(a), .B(b), .sel(sel),
        .Out(out), .N(n), .Z(z), .V(v), .C(c), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // Reference model built from plain integer arithmetic and bit-by-bit shift loops.
    function automatic logic [W+3:0] model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ua = longint'(x);
        longint ub = longint'(y);
        longint sa = x[W-1] ? ua - (longint'(1) << W) : ua;
        longint sbv = y[W-1] ? ub - (longint'(1) << W) : ub;
        longint r = 0;
        longint t;
        logic cc = 1'b0;
        logic vv = 1'b0;
        logic [W-1:0] o;
        case (s)
            4'h0: r = ua & ub;
            4'h1: r = ua | ub;
            4'h2: r = ua ^ ub;
            4'h3: r = ~ua & MK;
            4'h4: begin
                t = ua + ub; r = t & MK; cc = t > MK;
                t = sa + sbv; vv = (t >= HALF) || (t < -HALF);
            end
            4'h5, 4'hD: begin
                r = (ua - ub) & MK; cc = ua >= ub;
                t = sa - sbv; vv = (t >= HALF) || (t < -HALF);
            end
            4'h6, 4'hC: begin
`ifdef ALU_DIV_EN
                if (ub == 0) begin r = MK; vv = 1'b1; end
                else r = (s == 4'h6) ? ua / ub : ua % ub;
`else
                vv = 1'b1;
`endif
            end
            4'h7: begin
                t = ua * ub; r = t & MK; cc = (t >> W) != 0; vv = cc;
            end
            4'h8: begin
                r = ua;
                for (int i = 0; i < int'(y[4:0]); i++) begin cc = r[W-1]; r = (r << 1) & MK; end
            end
            4'h9: begin
                r = ua;
                for (int i = 0; i < int'(y[4:0]); i++) begin cc = r[0]; r = r >> 1; end
            end
            4'hA: begin
                r = ua;
                for (int i = 0; i < int'(y[4:0]); i++) begin cc = r[0]; r = (r >> 1) | (r & HALF); end
            end
            4'hB: r = ub;
            4'hE: r = (ua < ub) ? ua : ub;
            default: r = (ua > ub) ? ua : ub;
        endcase
        o = r[W-1:0];
        return {o, o[W-1], o == '0, vv, cc};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        flag_we = 1'b1;
        sel = 4'h4; a = '1; b = 19'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (flags_q !== 4'b0) begin
            errors++;
            $display("FAIL reset flags_q got=%b exp=0000", flags_q);
        end
        @(negedge clk);
        flag_we = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0]   ts[15];
        logic [W-1:0] ta[15], tb_[15];
        logic [W+3:0] te[15];
        ts = '{4'h4, 4'h5, 4'h5, 4'h7, 4'h7, 4'h6, 4'h6, 4'h4, 4'h4, 4'h8, 4'h8, 4'hA, 4'h9, 4'hC, 4'hD};
        ta = '{19'd3, 19'd7, 19'd6, 19'd3, 19'h40000, 19'd4, 19'd4, 19'h3FFFF, 19'h7FFFF,
               19'd1, 19'd1, 19'h40000, 19'h7FFFF, 19'd7, 19'd5};
        tb_ = '{19'd1, 19'd6, 19'd7, 19'd2, 19'd2, 19'd2, 19'd0, 19'd1, 19'd1,
                19'd18, 19'd19, 19'd25, 19'd0, 19'd3, 19'd5};
        te = '{{19'd4, 4'b0000}, {19'd1, 4'b0001}, {19'h7FFFF, 4'b1000}, {19'd6, 4'b0000},
               {19'd0, 4'b0111},
`ifdef ALU_DIV_EN
               {19'd2, 4'b0000}, {19'h7FFFF, 4'b1010},
`else
               {19'd0, 4'b0110}, {19'd0, 4'b0110},
`endif
               {19'h40000, 4'b1010}, {19'd0, 4'b0101},
               {19'h40000, 4'b1000}, {19'd0, 4'b0101}, {19'h7FFFF, 4'b1001}, {19'h7FFFF, 4'b1000},
`ifdef ALU_DIV_EN
               {19'd1, 4'b0000},
`else
               {19'd0, 4'b0110},
`endif
               {19'd0, 4'b0101}};
        for (int i = 0; i < 15; i++) begin
            sel = ts[i]; a = ta[i]; b = tb_[i];
            sb.push_back(te[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({out, n, z, v, c} !== e) begin
                errors++;
                $display("FAIL directed%0d sel=%h A=%h B=%h got=%h/%b exp=%h/%b",
                         i, sel, a, b, out, {n, z, v, c}, e[W+3:4], e[3:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] pick[5];
        for (int i = 0; i < 400; i++) begin
            pick = '{'0, 19'd1, '1, 19'h40000, W'($urandom)};
            sel = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : W'($urandom);
            if (sel inside {4'h8, 4'h9, 4'hA} && $urandom_range(0, 1) == 1)
                b = W'($urandom_range(0, 31));
            sb.push_back(model(sel, a, b));
            #1;
            e = sb.pop_front();
            checks++;
            if ({out, n, z, v, c} !== e) begin
                errors++;
                $display("FAIL random%0d sel=%h A=%h B=%h got=%h/%b exp=%h/%b",
                         i, sel, a, b, out, {n, z, v, c}, e[W+3:4], e[3:0]);
            end
        end
    endtask

    task automatic test_flags();
        logic [3:0] exp_q;
        // capture ADD overflow-to-zero case
        @(negedge clk);
        sel = 4'h4; a = '1; b = 19'd1; flag_we = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 4'b0101) begin errors++; $display("FAIL capture got=%b exp=0101", flags_q); end
        // hold while flag_we low even though flags change
        @(negedge clk);
        flag_we = 1'b0; sel = 4'h5; a = 19'd6; b = 19'd7;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 4'b0101) begin errors++; $display("FAIL hold got=%b exp=0101", flags_q); end
        // capture a different pattern
        @(negedge clk);
        flag_we = 1'b1;
        exp_q = model(sel, a, b);
        @(posedge clk); #1;
        checks++;
        if (flags_q !== exp_q) begin errors++; $display("FAIL capture2 got=%b exp=%b", flags_q, exp_q); end
        // asynchronous reset mid-cycle clears at once
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (flags_q !== 4'b0) begin errors++; $display("FAIL async_rst got=%b exp=0000", flags_q); end
        // flag_we ignored while reset held
        sel = 4'h4; a = '1; b = 19'd1;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 4'b0) begin errors++; $display("FAIL rst_we got=%b exp=0000", flags_q); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 4'b0101) begin errors++; $display("FAIL post_rst got=%b exp=0101", flags_q); end
        @(negedge clk);
        flag_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
